// File: rtl/multicycle_control32.sv
// multicycle_control32: multi-cycle IF/ID/EX/MEM/WB sequencer for the 32-bit MIPS datapath.
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   opcode, funct           IR fields; instruction is the full IR (0 = halt)
//   alu_zero, alu_result    ALU flag (EX) and effective address (MEM)
//   mem_ready               memory/IO access-complete acknowledge
//   state                   current state code (IF=0 ID=1 EX=2 MEM=3 WB=4 HALT=5)
//   ir_write..pc_branch     IR load and PC update strobes
//   reg_write..mem_to_reg   register-file write controls
//   mem_*/io_*              bus strobes, exactly one high during a MEM access
//   instr_done              one-cycle pulse in the IF cycle after an instruction retires
//   halted, bus_error       HALT indicator, sticky MEM timeout flag
module multicycle_control32 #(
   parameter int          TIMEOUT  = 16,
   parameter logic [31:0] IO_ADDR1 = 32'h0000_3FFF,
   parameter logic [31:0] IO_ADDR2 = 32'h0000_3FFB
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic [31:0] instruction,
   input  logic        alu_zero,
   input  logic [31:0] alu_result,
   input  logic        mem_ready,
   output logic [2:0]  state,
   output logic        ir_write,
   output logic        pc_inc,
   output logic        pc_jump,
   output logic        pc_jr,
   output logic        pc_branch,
   output logic        reg_write,
   output logic        reg_dst,
   output logic        jal_link,
   output logic        mem_to_reg,
   output logic        mem_read,
   output logic        mem_write,
   output logic        io_read1,
   output logic        io_write1,
   output logic        io_read2,
   output logic        io_write2,
   output logic        instr_done,
   output logic        halted,
   output logic        bus_error
);
   typedef enum logic [2:0] {IF_S = 3'd0, ID_S = 3'd1, EX_S = 3'd2, MEM_S = 3'd3, WB_S = 3'd4, HALT_S = 3'd5} state_t;
   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
   state_t state_q, nxt;
   logic [CW-1:0] cnt_q;
   logic done_q;
   logic is_r, is_lw, is_sw, is_imm, is_jr, sel1, sel2, sel_mem, timeout;
   assign is_r    = opcode == 6'b000000;
   assign is_lw   = opcode == 6'b100011;
   assign is_sw   = opcode == 6'b101011;
   assign is_imm  = opcode[5:3] == 3'b001;
   assign is_jr   = is_r && funct == 6'b001000;
   assign sel1    = alu_result == IO_ADDR1;
   assign sel2    = !sel1 && alu_result == IO_ADDR2;
   assign sel_mem = !sel1 && !sel2;
   // ready takes priority: a timeout only counts when the final wait cycle sees no ready
   assign timeout = !mem_ready && cnt_q == LAST;
   assign state      = state_q;
   assign halted     = state_q == HALT_S;
   assign instr_done = done_q && !reset;
   always_comb begin
      nxt = IF_S;
      {ir_write, pc_inc, pc_jump, pc_jr, pc_branch, reg_write, reg_dst, jal_link, mem_to_reg} = '0;
      {mem_read, mem_write, io_read1, io_write1, io_read2, io_write2} = '0;
      case (state_q)
         IF_S: begin
            ir_write = 1'b1;
            pc_inc   = 1'b1;
            nxt      = ID_S;
         end
         ID_S: begin
            if (instruction == 32'd0) nxt = HALT_S;
            else if (opcode == 6'b000010) pc_jump = 1'b1;
            else if (opcode == 6'b000011) {pc_jump, reg_write, jal_link} = 3'b111;
            else if (is_jr) pc_jr = 1'b1;
            else nxt = EX_S;
         end
         EX_S: begin
            pc_branch = (opcode == 6'b000100 && alu_zero) || (opcode == 6'b000101 && !alu_zero);
            nxt = (is_r || is_imm) ? WB_S : (is_lw || is_sw) ? MEM_S : IF_S;
         end
         MEM_S: begin
            mem_read  = is_lw && sel_mem;
            mem_write = is_sw && sel_mem;
            io_read1  = is_lw && sel1;
            io_write1 = is_sw && sel1;
            io_read2  = is_lw && sel2;
            io_write2 = is_sw && sel2;
            nxt = mem_ready ? (is_lw ? WB_S : IF_S) : timeout ? IF_S : MEM_S;
         end
         WB_S: begin
            reg_write  = 1'b1;
            reg_dst    = is_r;
            mem_to_reg = is_lw;
         end
         HALT_S: nxt = HALT_S;
         default: nxt = IF_S;
      endcase
      // strobes drop in the reset cycle itself, even mid-access
      if (reset) begin
         {ir_write, pc_inc, pc_jump, pc_jr, pc_branch, reg_write, reg_dst, jal_link, mem_to_reg} = '0;
         {mem_read, mem_write, io_read1, io_write1, io_read2, io_write2} = '0;
      end
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IF_S;
         cnt_q     <= '0;
         bus_error <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= nxt;
         cnt_q     <= (state_q == MEM_S && nxt == MEM_S) ? cnt_q + 1'b1 : '0;
         bus_error <= bus_error || (state_q == MEM_S && timeout);
         done_q    <= nxt == IF_S && state_q inside {ID_S, EX_S, MEM_S, WB_S};
      end
   end
endmodule

// File: tb/tb_multicycle_control32.sv
// tb_multicycle_control32: per-instruction cycle-sequence model with per-cycle comparison against the sequencer.
module tb_multicycle_control32;
   localparam int TMO = 16;
   localparam logic [14:0] IRW = 15'h4000, PCI = 15'h2000, PCJ = 15'h1000, PCR = 15'h0800, PCB = 15'h0400,
                           RGW = 15'h0200, RDST = 15'h0100, JAL = 15'h0080, M2R = 15'h0040,
                           MR = 15'h0020, MW = 15'h0010, IOR1 = 15'h0008, IOW1 = 15'h0004,
                           IOR2 = 15'h0002, IOW2 = 15'h0001;
   typedef struct packed {
      logic v;
      logic rst;
      logic rdy;
      logic [2:0] st;
      logic [14:0] sb;
      logic done;
      logic halt;
      logic berr;
   } cyc_t;
   logic clock = 1'b0, reset = 1'b1, alu_zero = 1'b0, mem_ready = 1'b0;
   logic [5:0] opcode = '0, funct = '0;
   logic [31:0] instruction = '0, alu_result = '0;
   logic [2:0] state;
   logic ir_write, pc_inc, pc_jump, pc_jr, pc_branch, reg_write, reg_dst, jal_link, mem_to_reg;
   logic mem_read, mem_write, io_read1, io_write1, io_read2, io_write2, instr_done, halted, bus_error;
   cyc_t q[$];
   logic m_done = 1'b0, m_berr = 1'b0;
   int n_checks = 0, n_errs = 0, n_rd = 0, n_busy = 0, n_wb = 0, n_halt = 0;
   multicycle_control32 #(.TIMEOUT(TMO)) dut (
      .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .instruction(instruction),
      .alu_zero(alu_zero), .alu_result(alu_result), .mem_ready(mem_ready), .state(state),
      .ir_write(ir_write), .pc_inc(pc_inc), .pc_jump(pc_jump), .pc_jr(pc_jr), .pc_branch(pc_branch),
      .reg_write(reg_write), .reg_dst(reg_dst), .jal_link(jal_link), .mem_to_reg(mem_to_reg),
      .mem_read(mem_read), .mem_write(mem_write), .io_read1(io_read1), .io_write1(io_write1),
      .io_read2(io_read2), .io_write2(io_write2), .instr_done(instr_done), .halted(halted),
      .bus_error(bus_error));
   always #5 clock = ~clock;
   task automatic push(input logic [2:0] st, input logic [14:0] sb, input logic rdy, input logic rst);
      q.push_back('{v: 1'b1, rst: rst, rdy: rdy, st: st, sb: sb, done: m_done, halt: st == 3'd5, berr: m_berr});
      m_done = 1'b0;
   endtask
   // Expected cycle sequence of one instruction; ready_at = MEM cycle that sees ready (0 = never),
   // cut > 0 stops after that many MEM cycles without retiring (used for a reset mid-access).
   task automatic model(input logic [31:0] ins, input int ready_at, input int cut);
      logic [5:0] op, fn;
      logic lw, ls;
      logic [14:0] stb;
      int n;
      op = ins[31:26];
      fn = ins[5:0];
      lw = op == 6'h23;
      ls = lw || op == 6'h2B;
      push(3'd0, IRW | PCI, 1'b0, 1'b0);
      if (ins == 32'd0) begin
         push(3'd1, 15'd0, 1'b0, 1'b0);
         for (int i = 0; i < 20; i++) push(3'd5, 15'd0, 1'b0, 1'b0);
         return;
      end
      if (op == 6'h02) push(3'd1, PCJ, 1'b0, 1'b0);
      else if (op == 6'h03) push(3'd1, PCJ | RGW | JAL, 1'b0, 1'b0);
      else if (op == 6'h00 && fn == 6'h08) push(3'd1, PCR, 1'b0, 1'b0);
      else begin
         push(3'd1, 15'd0, 1'b0, 1'b0);
         push(3'd2, ((op == 6'h04 && alu_zero) || (op == 6'h05 && !alu_zero)) ? PCB : 15'd0, 1'b0, 1'b0);
         if (ls) begin
            stb = alu_result == 32'h3FFF ? (lw ? IOR1 : IOW1) : alu_result == 32'h3FFB ? (lw ? IOR2 : IOW2) : (lw ? MR : MW);
            n = ready_at == 0 ? TMO : ready_at;
            if (cut > 0) n = cut;
            for (int i = 1; i <= n; i++) push(3'd3, stb, i == ready_at, 1'b0);
            if (cut > 0) return;
            if (ready_at == 0) m_berr = 1'b1;
            else if (lw) push(3'd4, RGW | M2R, 1'b0, 1'b0);
         end else if (op == 6'h00 || op[5:3] == 3'b001) push(3'd4, RGW | (op == 6'h00 ? RDST : 15'd0), 1'b0, 1'b0);
      end
      m_done = 1'b1;
   endtask
   task automatic run(input string nm);
      cyc_t c;
      logic [20:0] got, exp;
      while (q.size() > 0) begin
         c = q.pop_front();
         reset = c.rst;
         mem_ready = c.rdy;
         @(negedge clock);
         got = {state, ir_write, pc_inc, pc_jump, pc_jr, pc_branch, reg_write, reg_dst, jal_link, mem_to_reg,
                mem_read, mem_write, io_read1, io_write1, io_read2, io_write2, instr_done, halted, bus_error};
         exp = {c.st, c.sb, c.done, c.halt, c.berr};
         if (c.v) begin
            n_checks++;
            if (got !== exp) begin
               n_errs++;
               $display("FAIL %s @%0t: got st=%0d sb=%b done=%b halt=%b berr=%b, expected st=%0d sb=%b done=%b halt=%b berr=%b",
                        nm, $time, got[20:18], got[17:3], got[2], got[1], got[0], exp[20:18], exp[17:3], exp[2], exp[1], exp[0]);
            end
         end
         n_rd   += int'(mem_read);
         n_busy += int'(mem_read | mem_write | io_read1 | io_write1 | io_read2 | io_write2);
         n_wb   += int'(reg_write);
         n_halt += int'(halted);
         @(posedge clock);
         #1;
      end
   endtask
   task automatic eq(input string nm, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errs++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
      end
   endtask
   task automatic instr(input string nm, input logic [31:0] ins, input logic az, input logic [31:0] addr,
                        input int ready_at, input int cut, input int len);
      instruction = ins;
      opcode = ins[31:26];
      funct = ins[5:0];
      alu_zero = az;
      alu_result = addr;
      model(ins, ready_at, cut);
      if (len > 0) eq({nm, "_len"}, q.size(), len);
      run(nm);
   endtask
   initial begin
      int b;
      @(posedge clock);
      #1;
      push(3'd0, 15'd0, 1'b0, 1'b1);
      run("reset");
      b = n_wb;
      instr("add", 32'h012A_4020, 1'b0, 32'h0, 0, 0, 4);
      eq("add_wb_cycles", n_wb - b, 1);
      b = n_rd;
      instr("lw_wait", 32'h8D09_0000, 1'b0, 32'h10, 3, 0, 7);
      eq("lw_wait_read_cycles", n_rd - b, 3);
      b = n_busy;
      instr("sw_io2", 32'hAD09_0000, 1'b0, 32'h3FFB, 1, 0, 4);
      eq("sw_io2_busy", n_busy - b, 1);
      b = n_busy;
      instr("lw_io1", 32'h8D09_0000, 1'b0, 32'h3FFF, 1, 0, 5);
      eq("lw_io1_busy", n_busy - b, 1);
      instr("sw_io1", 32'hAD09_0000, 1'b0, 32'h3FFF, 2, 0, 5);
      instr("lw_io2", 32'h8D09_0000, 1'b0, 32'h3FFB, 1, 0, 5);
      instr("sw_mem", 32'hAD09_0000, 1'b0, 32'h3FFC, 1, 0, 4);
      instr("beq_taken", 32'h1109_0003, 1'b1, 32'h0, 0, 0, 3);
      instr("bne_not", 32'h1509_0003, 1'b1, 32'h0, 0, 0, 3);
      instr("bne_taken", 32'h1509_0003, 1'b0, 32'h0, 0, 0, 3);
      instr("beq_not", 32'h1109_0003, 1'b0, 32'h0, 0, 0, 3);
      instr("j", 32'h0800_0010, 1'b0, 32'h0, 0, 0, 2);
      instr("jal", 32'h0C00_0010, 1'b0, 32'h0, 0, 0, 2);
      instr("jr", 32'h0100_0008, 1'b0, 32'h0, 0, 0, 2);
      instr("ori", 32'h3509_00FF, 1'b0, 32'h0, 0, 0, 4);
      instr("nop_blez", 32'h1900_0000, 1'b0, 32'h0, 0, 0, 3);
      instr("lw_cut", 32'h8D09_0000, 1'b0, 32'h10, 0, 3, 6);
      push(3'd3, 15'd0, 1'b0, 1'b1);
      m_done = 1'b0;
      m_berr = 1'b0;
      run("reset_mid_mem");
      instr("add_after_rst", 32'h012A_4020, 1'b0, 32'h0, 0, 0, 4);
      b = n_rd;
      instr("lw_timeout", 32'h8D09_0000, 1'b0, 32'h10, 0, 0, 19);
      eq("lw_timeout_read_cycles", n_rd - b, 16);
      instr("lw_after_tmo", 32'h8D09_0000, 1'b0, 32'h20, 1, 0, 5);
      b = n_halt;
      instr("halt", 32'h0, 1'b0, 32'h0, 0, 0, 22);
      eq("halt_cycles", n_halt - b, 20);
      q.push_back('{v: 1'b0, rst: 1'b1, rdy: 1'b0, st: 3'd5, sb: 15'd0, done: 1'b0, halt: 1'b0, berr: 1'b0});
      m_done = 1'b0;
      m_berr = 1'b0;
      run("halt_reset");
      instr("add_after_halt", 32'h012A_4020, 1'b0, 32'h0, 0, 0, 4);
      instr("j_last", 32'h0800_0010, 1'b0, 32'h0, 0, 0, 2);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end
endmodule

// File: doc/multicycle_control32.md
# multicycle_control32

Multi-cycle sequencer for the 32-bit MIPS datapath. It steps each instruction through fetch, decode, execute, memory and write-back states, and drives the datapath and memory/IO strobes from the current state and the decoded opcode. Memory and IO accesses use a ready handshake guarded by a timeout. The block sits between the instruction register and the datapath, taking over the sequencing role that the single-cycle decoder cannot provide.

## Interface
Parameters:
- TIMEOUT, 16: maximum MEM-state cycles without `mem_ready` before the access is aborted (≥2).
- IO_ADDR1, 32'h0000_3FFF: address of IO device 1.
- IO_ADDR2, 32'h0000_3FFB: address of IO device 2.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  6  instruction[31:26] from the IR; stable from ID onward.
- funct  in  6  instruction[5:0] from the IR.
- instruction  in  32  full IR; the value 0 means halt.
- alu_zero  in  1  ALU zero flag, valid in EX.
- alu_result  in  32  effective address, valid in MEM.
- mem_ready  in  1  memory/IO access-complete acknowledge.
- state  out  3  current state code.
- ir_write, pc_inc, pc_jump, pc_jr, pc_branch  out  1 each  IR load strobe and PC update strobes.
- reg_write, reg_dst, jal_link, mem_to_reg  out  1 each  register-file write controls.
- mem_read, mem_write, io_read1, io_write1, io_read2, io_write2  out  1 each  bus strobes.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- halted  out  1  high in HALT.
- bus_error  out  1  sticky timeout flag.

## Operation
- State codes: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 return to IF.
- Outputs are Moore-style: a combinational function of the state, opcode and funct, plus the registered flags.
- **IF:** `ir_write=1` and `pc_inc=1`. Next state is ID.
- **ID:**
  - `instruction==0` → HALT.
  - j (000010) → `pc_jump=1`, then IF.
  - jal (000011) → `pc_jump=1`, `reg_write=1`, `jal_link=1`, then IF.
  - jr (op 0, funct 001000) → `pc_jr=1`, then IF.
  - Any other opcode → EX.
- **EX:**
  - beq (000100) → `pc_branch=alu_zero`, then IF.
  - bne (000101) → `pc_branch=!alu_zero`, then IF.
  - R-format or opcode[5:3]=001 → WB.
  - lw (100011) or sw (101011) → MEM.
  - Any other opcode → IF, treated as a nop.
- **MEM:**
  - Target select: `alu_result==IO_ADDR1` selects io*1, `==IO_ADDR2` selects io*2, anything else selects mem_*.
  - lw asserts the selected read strobe; sw asserts the selected write strobe. Exactly one strobe is high.
  - The strobe is held until `mem_ready=1` is sampled.
  - On ready: lw → WB; sw → IF.
  - Wait counter: reset to 0 on MEM entry, +1 on each MEM cycle without ready.
  - If the counter equals TIMEOUT-1 and ready is low: set `bus_error`, go to IF, and skip write-back.
  - If ready and timeout occur in the same cycle, ready wins.
- **WB:** `reg_write=1`.
  - `reg_dst=1` for R-format.
  - `mem_to_reg=1` for lw.
  - Next state is IF.
- **HALT:** `halted=1`, all strobes 0. Only reset leaves this state.
- **instr_done:** high for one cycle on every transition into IF from ID, EX, MEM or WB, including nops and aborts. Not asserted on reset exit.

## Timing
- **Reset:** `reset` is sampled on the clock edge. While it is high, the FSM is forced to IF and the wait counter, `bus_error` and `halted` are cleared. All strobe outputs and `instr_done` are forced to 0 during reset. This applies mid-access as well: a MEM strobe drops in the reset cycle.
- First cycle after reset deasserts is IF (`ir_write=1`).
- Cycles per instruction:
  - j/jal/jr: 2.
  - Branch or nop: 3.
  - R/I ALU op: 4.
  - sw: 3+N.
  - lw: 4+N.
  - N is the number of MEM cycles, ≥1; N=1 when `mem_ready=1` in the first MEM cycle.
  - Abort: N=TIMEOUT.
- `mem_ready` is ignored outside MEM.
- `bus_error` is set on the edge leaving MEM by timeout and stays high until reset.

## Test plan
- **ALU op:** reset 2 cycles, then `instruction`=add (op 0, funct 100000). State sequence 0,1,2,4,0. `reg_write=1` and `reg_dst=1` only in WB. `instr_done` pulses in cycle 5.
- **lw with wait:** `alu_result`=0x10, `mem_ready` raised on the 3rd MEM cycle. `mem_read` high for 3 cycles, then WB with `mem_to_reg=1`. Total 7 cycles.
- **IO decode:** sw with `alu_result`=0x3FFB and ready immediate → `io_write2` high for 1 cycle, all other strobes 0. Repeat with lw at 0x3FFF → only `io_read1` high.
- **Branches:** beq with `alu_zero`=1 → `pc_branch=1` in EX, 3 cycles total. bne with `alu_zero`=1 → `pc_branch=0`.
- **Timeout:** TIMEOUT=16, lw, `mem_ready` held at 0 → `mem_read` high for exactly 16 cycles, `bus_error`=1, next state IF, no WB. A second lw with ready immediate completes normally and `bus_error` stays 1.
- **Halt and reset:** `instruction`=0 → HALT after ID, `halted=1`, remains there 20 cycles. Assert reset for 1 cycle → IF, `halted=0`, `bus_error=0`. Reset asserted during a MEM wait → strobe 0 in that cycle, IF next.
